// File: rtl/swd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : swd_pkg
// Purpose  : Shared types and constants for the SWD responder: line-engine
//            state encoding, ACK codes, request bit positions and the
//            request header validity check.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package swd_pkg;

  typedef enum logic [3:0] {
    ST_LOCKOUT  = 4'd0,
    ST_RST_SEEN = 4'd1,
    ST_IDLE     = 4'd2,
    ST_REQ      = 4'd3,
    ST_TRN1     = 4'd4,
    ST_ACK      = 4'd5,
    ST_RDATA    = 4'd6,
    ST_TRN2     = 4'd7,
    ST_WDATA    = 4'd8
  } swd_state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int LINE_RESET_BITS_DEF = 50;

  // Request header bit positions, in the order they arrive on the wire.
  localparam int REQ_START  = 0;
  localparam int REQ_APNDP  = 1;
  localparam int REQ_RNW    = 2;
  localparam int REQ_A2     = 3;
  localparam int REQ_A3     = 4;
  localparam int REQ_PARITY = 5;
  localparam int REQ_STOP   = 6;
  localparam int REQ_PARK   = 7;

  localparam logic [5:0] REQ_LAST_BIT = 6'd7;
  localparam logic [5:0] DATA_BITS    = 6'd32;

  // Header is good when start=1, APnDP..A3 plus parity has even weight,
  // stop=0 and park=1.
  function automatic logic req_header_ok(input logic [7:0] hdr);
    return hdr[REQ_START]
         & ~(^hdr[REQ_PARITY:REQ_APNDP])
         & ~hdr[REQ_STOP]
         & hdr[REQ_PARK];
  endfunction

endpackage
`default_nettype wire

// File: rtl/swd_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : swd_responder_if
// Purpose  : Register-access strobe interface between the SWD line engine
//            and the DP/AP backend.
// Ports    : REQ_APnDP/REQ_ADDR  latched request target
//            RD_STB/RD_VALID/RD_DATA  read request and returned data
//            WR_STB/WR_DATA  captured write data
//            BUSY/FAULT  backend status that shapes the ACK
//            modport master = line engine, modport slave = backend
// Revision : 1.0  initial release
// ============================================================================
interface swd_responder_if;

  logic        REQ_APnDP;
  logic [1:0]  REQ_ADDR;
  logic        RD_STB;
  logic        RD_VALID;
  logic [31:0] RD_DATA;
  logic        WR_STB;
  logic [31:0] WR_DATA;
  logic        BUSY;
  logic        FAULT;

  modport master (
    output REQ_APnDP, REQ_ADDR, RD_STB, WR_STB, WR_DATA,
    input  RD_VALID, RD_DATA, BUSY, FAULT
  );

  modport slave (
    input  REQ_APnDP, REQ_ADDR, RD_STB, WR_STB, WR_DATA,
    output RD_VALID, RD_DATA, BUSY, FAULT
  );

endinterface
`default_nettype wire

// File: rtl/swd_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : swd_edge_sync
// Purpose  : Brings the asynchronous SWDCLK and SWDIN into the local clock
//            domain and flags each SWDCLK rising edge with a one-cycle pulse.
// Ports    : clk, rst_n   local clock, async active-low reset
//            swdclk       host SWD clock (async)
//            swdin        SWDIO input (async)
//            clk_rise     one-cycle pulse per SWDCLK rising edge
//            din_sample   synchronised SWDIN, valid when clk_rise is high
// Revision : 1.0  initial release
// ============================================================================
module swd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  swdclk,
  input  wire  swdin,
  output logic clk_rise,
  output logic din_sample
);

  // SWDCLK carries one extra flop beyond the synchroniser for edge detect.
  logic [SYNC_STAGES:0]   clk_sync;
  logic [SYNC_STAGES-1:0] din_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      din_sync <= '0;
    end else begin
      clk_sync[0] <= swdclk;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        clk_sync[i] <= clk_sync[i-1];
      end
      din_sync[0] <= swdin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        din_sync[i] <= din_sync[i-1];
      end
    end
  end

  // Data and clock travel through equal-depth chains, so the data tap at the
  // same depth as the edge tap reflects SWDIN around the host's rising edge.
  assign clk_rise   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES];
  assign din_sample = din_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/swd_responder.sv
`default_nettype none
// ============================================================================
// Module   : swd_responder
// Purpose  : SWD target-side line engine. Oversamples SWDCLK, parses 8-bit
//            requests, drives turnaround/ACK/read data, captures write data
//            and hands register accesses to a DP/AP backend.
// Ports    : CLK, PORESETn      local clock (>= 4x SWDCLK), async reset
//            SWDCLK, SWDIN      host clock and SWDIO input (async)
//            SWDOUT, SWDOE      SWDIO output data and drive enable
//            bus                backend strobe interface (master side)
//            LINE_RESET         pulse on line reset detection
//            PROTO_ERR          pulse on bad request header
//            WDATA_ERR          pulse on write-data parity error
// Revision : 1.0  initial release
// ============================================================================
module swd_responder
  import swd_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LINE_RESET_BITS = LINE_RESET_BITS_DEF
) (
  input  wire            CLK,
  input  wire            PORESETn,
  input  wire            SWDCLK,
  input  wire            SWDIN,
  output logic           SWDOUT,
  output logic           SWDOE,
  swd_responder_if.master bus,
  output logic           LINE_RESET,
  output logic           PROTO_ERR,
  output logic           WDATA_ERR
);

  localparam int LR_W = $clog2(LINE_RESET_BITS + 1);
  localparam logic [LR_W-1:0] LR_MAX  = LR_W'(LINE_RESET_BITS);
  localparam logic [LR_W-1:0] LR_LAST = LR_W'(LINE_RESET_BITS - 1);

  logic rise;
  logic sample;

  swd_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (CLK),
    .rst_n      (PORESETn),
    .swdclk     (SWDCLK),
    .swdin      (SWDIN),
    .clk_rise   (rise),
    .din_sample (sample)
  );

  // Registered state and datapath
  swd_state_e       state_q,      state_d;
  logic [5:0]       cnt_q,        cnt_d;
  logic [7:0]       req_bits_q,   req_bits_d;
  logic             is_read_q,    is_read_d;
  logic [2:0]       ack_q,        ack_d;
  logic [31:0]      rdata_q,      rdata_d;
  logic             rd_par_q,     rd_par_d;
  logic [31:0]      wshift_q,     wshift_d;
  logic [LR_W-1:0]  lr_cnt_q,     lr_cnt_d;

  // Registered outputs
  logic             swdout_q,     swdout_d;
  logic             swdoe_q,      swdoe_d;
  logic             rd_stb_q,     rd_stb_d;
  logic             wr_stb_q,     wr_stb_d;
  logic             line_reset_q, line_reset_d;
  logic             proto_err_q,  proto_err_d;
  logic             wdata_err_q,  wdata_err_d;
  logic             req_apndp_q,  req_apndp_d;
  logic [1:0]       req_addr_q,   req_addr_d;
  logic [31:0]      wr_data_q,    wr_data_d;

  // Combinational helpers
  logic             lr_hit;
  logic [7:0]       req_full;
  logic [2:0]       ack_sel;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_bits_d   = req_bits_q;
    is_read_d    = is_read_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    rd_par_d     = rd_par_q;
    wshift_d     = wshift_q;
    lr_cnt_d     = lr_cnt_q;
    swdout_d     = swdout_q;
    swdoe_d      = swdoe_q;
    rd_stb_d     = 1'b0;
    wr_stb_d     = 1'b0;
    line_reset_d = 1'b0;
    proto_err_d  = 1'b0;
    wdata_err_d  = 1'b0;
    req_apndp_d  = req_apndp_q;
    req_addr_d   = req_addr_q;
    wr_data_d    = wr_data_q;
    lr_hit       = 1'b0;

    // Header as it will look once the current sample is shifted in.
    req_full              = req_bits_q;
    req_full[cnt_q[2:0]]  = sample;

    // Response code, evaluated at the first turnaround edge.
    if (bus.FAULT) begin
      ack_sel = ACK_FAULT;
    end else if (bus.BUSY || (is_read_q && !bus.RD_VALID)) begin
      ack_sel = ACK_WAIT;
    end else begin
      ack_sel = ACK_OK;
    end

    // Line-reset run length: only ones seen while the line is not ours count.
    if (swdoe_q) begin
      lr_cnt_d = '0;
    end else if (rise) begin
      if (!sample) begin
        lr_cnt_d = '0;
      end else if (lr_cnt_q != LR_MAX) begin
        lr_cnt_d = lr_cnt_q + 1'b1;
        lr_hit   = (lr_cnt_q == LR_LAST);
      end
    end

    if (rise) begin
      if (lr_hit) begin
        // Line reset wins over whatever the non-driving state was doing.
        line_reset_d = 1'b1;
        state_d      = ST_RST_SEEN;
        cnt_d        = '0;
      end else begin
        unique case (state_q)
          ST_LOCKOUT: begin
            state_d = ST_LOCKOUT;
          end

          ST_RST_SEEN: begin
            if (!sample) begin
              state_d = ST_IDLE;
            end
          end

          ST_IDLE: begin
            if (sample) begin
              req_bits_d = 8'b0000_0001;
              cnt_d      = 6'd1;
              state_d    = ST_REQ;
            end
          end

          ST_REQ: begin
            req_bits_d = req_full;
            if (cnt_q == REQ_LAST_BIT) begin
              if (req_header_ok(req_full)) begin
                req_apndp_d = req_full[REQ_APNDP];
                req_addr_d  = {req_full[REQ_A3], req_full[REQ_A2]};
                is_read_d   = req_full[REQ_RNW];
                rd_stb_d    = req_full[REQ_RNW];
                state_d     = ST_TRN1;
              end else begin
                proto_err_d = 1'b1;
                state_d     = ST_LOCKOUT;
              end
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end

          ST_TRN1: begin
            ack_d    = ack_sel;
            swdoe_d  = 1'b1;
            swdout_d = ack_sel[0];
            cnt_d    = 6'd1;
            if (is_read_q && (ack_sel == ACK_OK)) begin
              rdata_d  = bus.RD_DATA;
              rd_par_d = ^bus.RD_DATA;
            end
            state_d  = ST_ACK;
          end

          ST_ACK: begin
            if (cnt_q == 6'd1) begin
              swdout_d = ack_q[1];
              cnt_d    = 6'd2;
            end else if (cnt_q == 6'd2) begin
              swdout_d = ack_q[2];
              cnt_d    = 6'd3;
            end else if (is_read_q && (ack_q == ACK_OK)) begin
              swdout_d = rdata_q[0];
              rdata_d  = {1'b0, rdata_q[31:1]};
              cnt_d    = 6'd1;
              state_d  = ST_RDATA;
            end else begin
              swdoe_d  = 1'b0;
              swdout_d = 1'b0;
              state_d  = ST_TRN2;
            end
          end

          ST_RDATA: begin
            // rdata_q is shifted right each bit so bit 0 is always next.
            if (cnt_q < DATA_BITS) begin
              swdout_d = rdata_q[0];
              rdata_d  = {1'b0, rdata_q[31:1]};
              cnt_d    = cnt_q + 6'd1;
            end else if (cnt_q == DATA_BITS) begin
              swdout_d = rd_par_q;
              cnt_d    = cnt_q + 6'd1;
            end else begin
              swdoe_d  = 1'b0;
              swdout_d = 1'b0;
              state_d  = ST_TRN2;
            end
          end

          ST_TRN2: begin
            if (!is_read_q && (ack_q == ACK_OK)) begin
              cnt_d   = '0;
              state_d = ST_WDATA;
            end else begin
              state_d = ST_IDLE;
            end
          end

          ST_WDATA: begin
            if (cnt_q < DATA_BITS) begin
              wshift_d = {sample, wshift_q[31:1]};
              cnt_d    = cnt_q + 6'd1;
            end else begin
              if ((^wshift_q) == sample) begin
                wr_data_d = wshift_q;
                wr_stb_d  = 1'b1;
              end else begin
                wdata_err_d = 1'b1;
              end
              state_d = ST_IDLE;
            end
          end

          default: begin
            swdoe_d = 1'b0;
            state_d = ST_LOCKOUT;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state_q      <= ST_LOCKOUT;
      cnt_q        <= '0;
      req_bits_q   <= '0;
      is_read_q    <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      rd_par_q     <= 1'b0;
      wshift_q     <= '0;
      lr_cnt_q     <= '0;
      swdout_q     <= 1'b0;
      swdoe_q      <= 1'b0;
      rd_stb_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      line_reset_q <= 1'b0;
      proto_err_q  <= 1'b0;
      wdata_err_q  <= 1'b0;
      req_apndp_q  <= 1'b0;
      req_addr_q   <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_bits_q   <= req_bits_d;
      is_read_q    <= is_read_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      rd_par_q     <= rd_par_d;
      wshift_q     <= wshift_d;
      lr_cnt_q     <= lr_cnt_d;
      swdout_q     <= swdout_d;
      swdoe_q      <= swdoe_d;
      rd_stb_q     <= rd_stb_d;
      wr_stb_q     <= wr_stb_d;
      line_reset_q <= line_reset_d;
      proto_err_q  <= proto_err_d;
      wdata_err_q  <= wdata_err_d;
      req_apndp_q  <= req_apndp_d;
      req_addr_q   <= req_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign SWDOUT        = swdout_q;
  assign SWDOE         = swdoe_q;
  assign LINE_RESET    = line_reset_q;
  assign PROTO_ERR     = proto_err_q;
  assign WDATA_ERR     = wdata_err_q;
  assign bus.REQ_APnDP = req_apndp_q;
  assign bus.REQ_ADDR  = req_addr_q;
  assign bus.RD_STB    = rd_stb_q;
  assign bus.WR_STB    = wr_stb_q;
  assign bus.WR_DATA   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_swd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_swd_responder
// Purpose  : Directed self-checking bench for swd_responder. The host side
//            of the SWD link is modelled bit by bit; the expected line
//            response for every host bit is queued before the bit is clocked.
// Ports    : none (top-level bench)
// Revision : 1.0  initial release
// ============================================================================
module tb_swd_responder;
  import swd_pkg::*;

  localparam int HALF = 5;   // CLK cycles per SWDCLK half period

  logic CLK      = 1'b0;
  logic PORESETn = 1'b0;
  logic SWDCLK   = 1'b0;
  logic SWDIN    = 1'b0;
  logic SWDOUT;
  logic SWDOE;
  logic LINE_RESET;
  logic PROTO_ERR;
  logic WDATA_ERR;

  swd_responder_if bus ();

  swd_responder #(
    .SYNC_STAGES     (2),
    .LINE_RESET_BITS (50)
  ) dut (
    .CLK        (CLK),
    .PORESETn   (PORESETn),
    .SWDCLK     (SWDCLK),
    .SWDIN      (SWDIN),
    .SWDOUT     (SWDOUT),
    .SWDOE      (SWDOE),
    .bus        (bus),
    .LINE_RESET (LINE_RESET),
    .PROTO_ERR  (PROTO_ERR),
    .WDATA_ERR  (WDATA_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse monitors
  int n_lr = 0, n_rd = 0, n_wr = 0, n_perr = 0, n_werr = 0;
  always @(posedge CLK) begin
    if (LINE_RESET)  n_lr   <= n_lr + 1;
    if (bus.RD_STB)  n_rd   <= n_rd + 1;
    if (bus.WR_STB)  n_wr   <= n_wr + 1;
    if (PROTO_ERR)   n_perr <= n_perr + 1;
    if (WDATA_ERR)   n_werr <= n_werr + 1;
  end

  // Scoreboard: host bit to drive, and {check_data, expected_oe, expected_out}
  logic       din_q[$];
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_bit(input logic din, input logic oe, input logic out, input logic chk);
    din_q.push_back(din);
    exp_q.push_back({chk, oe, out});
  endfunction

  // One SWDCLK period; returns the line as the host sees it at the rising edge.
  task automatic swd_bit(input logic din, output logic dout, output logic doe);
    SWDIN = din;
    repeat (HALF) @(negedge CLK);
    dout = SWDOUT;
    doe  = SWDOE;
    SWDCLK = 1'b1;
    repeat (HALF) @(negedge CLK);
    SWDCLK = 1'b0;
  endtask

  function automatic void build_lr(input int ones, input int zeros);
    for (int i = 0; i < ones; i++)  push_bit(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < zeros; i++) push_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // ack == 0 means the target must stay silent for the whole request.
  function automatic void build_xfer(input logic [7:0] req, input logic [2:0] ack,
                                     input logic [31:0] data, input logic par_flip);
    logic rnw;
    rnw = req[REQ_RNW];
    for (int i = 0; i < 8; i++) push_bit(req[i], 1'b0, 1'b0, 1'b0);
    if (ack == 3'b000) begin
      for (int i = 0; i < 4; i++) push_bit(1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      push_bit(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push_bit(1'b0, 1'b1, ack[i], 1'b1);
      if (ack == ACK_OK && rnw) begin
        for (int i = 0; i < 32; i++) push_bit(1'b0, 1'b1, data[i], 1'b1);
        push_bit(1'b0, 1'b1, ^data, 1'b1);
        push_bit(1'b0, 1'b0, 1'b0, 1'b0);
      end else if (ack == ACK_OK) begin
        push_bit(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) push_bit(data[i], 1'b0, 1'b0, 1'b0);
        push_bit((^data) ^ par_flip, 1'b0, 1'b0, 1'b0);
      end else begin
        push_bit(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    push_bit(1'b0, 1'b0, 1'b0, 1'b0);
    push_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Clock out all queued bits; abort_at >= 0 pulses PORESETn before that bit.
  task automatic drain(input string tag, input int abort_at);
    int   k;
    logic aborted;
    k = 0;
    aborted = 1'b0;
    while (din_q.size() > 0) begin
      logic       d, o, e;
      logic [2:0] x;
      if (k == abort_at) begin
        check($sformatf("%s oe_before_reset", tag), 32'(SWDOE), 32'd1);
        PORESETn = 1'b0;
        #1;
        check($sformatf("%s oe_in_reset", tag), 32'(SWDOE), 32'd0);
        repeat (3) @(negedge CLK);
        PORESETn = 1'b1;
        aborted = 1'b1;
      end
      d = din_q.pop_front();
      x = exp_q.pop_front();
      if (aborted) x = 3'b000;
      swd_bit(d, o, e);
      check($sformatf("%s oe@%0d", tag, k), 32'(e), 32'(x[1]));
      if (x[2]) check($sformatf("%s out@%0d", tag, k), 32'(o), 32'(x[0]));
      k++;
    end
  endtask

  initial begin
    int base;
    bus.RD_VALID = 1'b1;
    bus.RD_DATA  = 32'h2BA0_1477;
    bus.BUSY     = 1'b0;
    bus.FAULT    = 1'b0;
    repeat (4) @(negedge CLK);

    // Reset state
    check("rst SWDOUT",     32'(SWDOUT),        32'd0);
    check("rst SWDOE",      32'(SWDOE),         32'd0);
    check("rst REQ_APnDP",  32'(bus.REQ_APnDP), 32'd0);
    check("rst REQ_ADDR",   32'(bus.REQ_ADDR),  32'd0);
    check("rst WR_DATA",    bus.WR_DATA,        32'd0);
    check("rst RD_STB",     32'(bus.RD_STB),    32'd0);
    check("rst WR_STB",     32'(bus.WR_STB),    32'd0);
    check("rst LINE_RESET", 32'(LINE_RESET),    32'd0);
    PORESETn = 1'b1;
    repeat (2) @(negedge CLK);

    // Out of reset the engine is locked out
    build_xfer(8'hA5, 3'b000, 32'h0, 1'b0);
    drain("lockout_req", -1);
    check("lockout no RD_STB", n_rd, 0);

    // Line reset then DP IDCODE read
    build_lr(56, 2);
    drain("lr1", -1);
    check("lr1 LINE_RESET count", n_lr, 1);
    build_xfer(8'hA5, ACK_OK, 32'h2BA0_1477, 1'b0);
    drain("idcode", -1);
    check("idcode RD_STB count", n_rd, 1);
    check("idcode REQ_APnDP", 32'(bus.REQ_APnDP), 32'd0);
    check("idcode REQ_ADDR",  32'(bus.REQ_ADDR),  32'd0);

    // DP write
    build_xfer(8'h81, ACK_OK, 32'h0000_001E, 1'b0);
    drain("dpwr", -1);
    check("dpwr WR_STB count", n_wr, 1);
    check("dpwr WR_DATA", bus.WR_DATA, 32'h0000_001E);
    check("dpwr REQ_ADDR", 32'(bus.REQ_ADDR), 32'd0);
    check("dpwr REQ_APnDP", 32'(bus.REQ_APnDP), 32'd0);
    check("dpwr no WDATA_ERR", n_werr, 0);

    // BUSY read: WAIT, no data phase; next AP read accepted normally
    bus.BUSY = 1'b1;
    build_xfer(8'hA5, ACK_WAIT, 32'h0, 1'b0);
    drain("busy", -1);
    bus.BUSY = 1'b0;
    check("busy RD_STB count", n_rd, 2);
    bus.RD_DATA = 32'h1234_5678;
    build_xfer(8'hAF, ACK_OK, 32'h1234_5678, 1'b0);
    drain("apread", -1);
    check("apread RD_STB count", n_rd, 3);
    check("apread REQ_APnDP", 32'(bus.REQ_APnDP), 32'd1);
    check("apread REQ_ADDR", 32'(bus.REQ_ADDR), 32'd1);

    // Read with data not ready: WAIT
    bus.RD_VALID = 1'b0;
    build_xfer(8'hA5, ACK_WAIT, 32'h0, 1'b0);
    drain("notvalid", -1);
    bus.RD_VALID = 1'b1;

    // FAULT on a write: no data phase, no write strobe
    bus.FAULT = 1'b1;
    build_xfer(8'h81, ACK_FAULT, 32'h0, 1'b0);
    drain("fault", -1);
    bus.FAULT = 1'b0;
    check("fault WR_STB count", n_wr, 1);

    // Write with bad data parity
    build_xfer(8'h81, ACK_OK, 32'hDEAD_BEEF, 1'b1);
    drain("badpar", -1);
    check("badpar WDATA_ERR count", n_werr, 1);
    check("badpar WR_STB count", n_wr, 1);
    check("badpar WR_DATA kept", bus.WR_DATA, 32'h0000_001E);

    // Bad request parity: locked out until a full line reset
    base = n_rd;
    build_xfer(8'h85, 3'b000, 32'h0, 1'b0);
    drain("perr", -1);
    check("perr PROTO_ERR count", n_perr, 1);
    build_xfer(8'hA5, 3'b000, 32'h0, 1'b0);
    drain("perr_ignored", -1);
    build_lr(49, 1);
    drain("lr49", -1);
    check("lr49 no LINE_RESET", n_lr, 1);
    build_xfer(8'hA5, 3'b000, 32'h0, 1'b0);
    drain("lr49_ignored", -1);
    check("perr no RD_STB", n_rd, base);
    build_lr(50, 2);
    drain("lr50", -1);
    check("lr50 LINE_RESET count", n_lr, 2);
    bus.RD_DATA = 32'hCAFE_F00D;
    build_xfer(8'hA5, ACK_OK, 32'hCAFE_F00D, 1'b0);
    drain("post_lr50", -1);
    check("post_lr50 RD_STB count", n_rd, base + 1);

    // Reset during read data bit 10 (host edge 22 samples it)
    build_xfer(8'hA5, ACK_OK, 32'hCAFE_F00D, 1'b0);
    drain("abort", 22);
    base = n_rd;
    build_xfer(8'hA5, 3'b000, 32'h0, 1'b0);
    drain("abort_ignored", -1);
    check("abort no RD_STB", n_rd, base);
    build_lr(50, 2);
    drain("lr_after_abort", -1);
    check("abort LINE_RESET count", n_lr, 3);
    bus.RD_DATA = 32'h8000_0001;
    build_xfer(8'hA5, ACK_OK, 32'h8000_0001, 1'b0);
    drain("recovered", -1);
    check("recovered RD_STB count", n_rd, base + 1);
    check("total PROTO_ERR", n_perr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: bench did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
